// File: rtl/fab_input_pkg.sv
// Shared constants for the fabric push-button / DIP-switch conditioning block.
package fab_input_pkg;

  localparam int FAB_IN_WIDTH      = 6;
  localparam int PB_LSB            = 0;
  localparam int DIPSW_LSB         = 2;
  localparam int DEBOUNCE_10MS_25M = 250000;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Counter width able to hold 0..cycles-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/fab_input_debounce_bit.sv
// One input bit: synchroniser chain, stability counter, debounced level and
// registered rise/fall pulses that coincide with the first cycle of a new level.
module debounce_bit
  import fab_input_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_25M,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  logic          sync_bit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // A sample matching the current level restarts qualification, so the
  // counter only ever runs while a candidate level is continuously present.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_bit == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync_bit;
      rise_d  = sync_bit;
      fall_d  = ~sync_bit;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/fab_input_debounce.sv
// Debounces the PB/DIPSW pad inputs ahead of the PIO exports and keeps a
// write-1-to-clear sticky edge register with a masked level interrupt.
module fab_input_debounce
  import fab_input_pkg::*;
#(
  parameter int               WIDTH           = FAB_IN_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS_25M,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}},
  parameter logic [1:0]       EDGE_MODE       = EDGE_BOTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_capture,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq
);

  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] set_w, clr_w;
  logic             irq_q, irq_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw_in[i]),
      .level_o(db_level[i]),
      .rise_o (rise_pulse[i]),
      .fall_o (fall_pulse[i])
    );
  end

  // Set is OR-ed in after the clear so an edge landing on a clear is kept.
  always_comb begin
    set_w = (rise_pulse & {WIDTH{EDGE_MODE[0]}}) |
            (fall_pulse & {WIDTH{EDGE_MODE[1]}});
    clr_w = clr_valid ? clr_mask : '0;
    cap_d = (cap_q & ~clr_w) | set_w;
    irq_d = |(cap_q & irq_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      irq_q <= irq_d;
    end
  end

  assign edge_capture = cap_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_fab_input_debounce.sv
// Directed bench: DEBOUNCE_CYCLES = 8, SYNC_STAGES = 2; a second instance
// runs with rise-only edge capture.
module tb_fab_input_debounce;
  import fab_input_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in, clr_mask, irq_mask;
  logic         clr_valid;
  logic [W-1:0] db_level, rise_pulse, fall_pulse, edge_capture;
  logic         irq;

  logic [W-1:0] raw2, db2, rise2, fall2, cap2;
  logic         irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fab_input_debounce #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
    .RESET_LEVEL(6'h3F), .EDGE_MODE(EDGE_BOTH)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .db_level(db_level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_capture(edge_capture), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .irq_mask(irq_mask), .irq(irq)
  );

  fab_input_debounce #(
    .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
    .RESET_LEVEL(6'h3F), .EDGE_MODE(EDGE_RISE)
  ) dut_rise (
    .clk(clk), .reset(reset), .raw_in(raw2),
    .db_level(db2), .rise_pulse(rise2), .fall_pulse(fall2),
    .edge_capture(cap2), .clr_valid(1'b0), .clr_mask(6'h00),
    .irq_mask(6'h3F), .irq(irq2)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    raw_in    = 6'h3F;
    raw2      = 6'h3F;
    clr_valid = 1'b0;
    clr_mask  = 6'h00;
    irq_mask  = 6'h01;

    // 1. reset state, then idle with all inputs high
    cyc(2);
    chk("rst_db", 32'(db_level), 32'h3F);
    chk("rst_pulse", 32'({rise_pulse, fall_pulse}), 32'h0);
    chk("rst_cap", 32'(edge_capture), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      chk("idle_db", 32'(db_level), 32'h3F);
      chk("idle_pulse", 32'({rise_pulse, fall_pulse}), 32'h0);
      chk("idle_cap", 32'(edge_capture), 32'h0);
      chk("idle_irq", 32'(irq), 32'h0);
    end

    // 2. clean fall on bit 0: level moves on the 10th sampling edge
    raw_in[0] = 1'b0;
    cyc(9);
    chk("t2_db_hold", 32'(db_level[0]), 32'h1);
    chk("t2_fall_early", 32'(fall_pulse), 32'h0);
    cyc(1);
    chk("t2_db_fell", 32'(db_level), 32'h3E);
    chk("t2_fall", 32'(fall_pulse), 32'h01);
    chk("t2_rise", 32'(rise_pulse), 32'h00);
    chk("t2_cap_pre", 32'(edge_capture), 32'h00);
    cyc(1);
    chk("t2_fall_end", 32'(fall_pulse), 32'h00);
    chk("t2_cap", 32'(edge_capture), 32'h01);
    chk("t2_irq_pre", 32'(irq), 32'h0);
    cyc(1);
    chk("t2_irq", 32'(irq), 32'h1);

    // 3. bounce on bit 1: 0 x5, 1 x2, then 0 held; single fall 10 clocks
    //    after the final 1->0 (driven at step 7)
    for (int k = 0; k < 30; k++) begin
      raw_in[1] = (k >= 5 && k < 7) ? 1'b1 : 1'b0;
      cyc(1);
      chk("t3_fall1", 32'(fall_pulse[1]), (k + 1 == 17) ? 32'h1 : 32'h0);
      chk("t3_rise1", 32'(rise_pulse[1]), 32'h0);
    end
    chk("t3_db", 32'(db_level), 32'h3C);
    chk("t3_cap", 32'(edge_capture), 32'h03);

    // 4. clear colliding with a new fall keeps the bit; next clear drops it
    raw_in[0] = 1'b1;
    cyc(12);
    chk("t4_db_up", 32'(db_level[0]), 32'h1);
    clr_valid = 1'b1;
    clr_mask  = 6'h3F;
    cyc(1);
    clr_valid = 1'b0;
    chk("t4_clr_all", 32'(edge_capture), 32'h00);
    cyc(1);
    chk("t4_irq_off", 32'(irq), 32'h0);
    raw_in[0] = 1'b0;
    cyc(10);
    chk("t4_fall", 32'(fall_pulse), 32'h01);
    clr_valid = 1'b1;
    clr_mask  = 6'h01;
    cyc(1);
    chk("t4_set_wins", 32'(edge_capture), 32'h01);
    cyc(1);
    clr_valid = 1'b0;
    chk("t4_cleared", 32'(edge_capture), 32'h00);
    chk("t4_irq_lag", 32'(irq), 32'h1);
    cyc(1);
    chk("t4_irq_drop", 32'(irq), 32'h0);

    // 5. reset mid-count on bit 3 (cnt = 5) discards the count
    raw_in[3] = 1'b0;
    cyc(7);
    chk("t5_db3_pre", 32'(db_level[3]), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_rst_db", 32'(db_level), 32'h3F);
    cyc(2);
    reset = 1'b0;
    cyc(9);
    chk("t5_db_hold", 32'(db_level), 32'h3F);
    chk("t5_no_cap", 32'(edge_capture), 32'h00);
    chk("t5_no_pulse", 32'({rise_pulse, fall_pulse}), 32'h0);
    cyc(1);
    chk("t5_db", 32'(db_level), 32'h34);
    chk("t5_fall", 32'(fall_pulse), 32'h0B);

    // 6. rise-only capture on bit 2 of the second instance
    raw2[2] = 1'b0;
    cyc(20);
    chk("t6_db_low", 32'(db2), 32'h3B);
    chk("t6_no_fall_cap", 32'(cap2), 32'h00);
    chk("t6_irq_off", 32'(irq2), 32'h0);
    raw2[2] = 1'b1;
    cyc(9);
    chk("t6_rise_early", 32'(rise2), 32'h00);
    cyc(1);
    chk("t6_rise", 32'(rise2), 32'h04);
    chk("t6_fall_none", 32'(fall2), 32'h00);
    cyc(1);
    chk("t6_rise_end", 32'(rise2), 32'h00);
    chk("t6_cap", 32'(cap2), 32'h04);
    cyc(1);
    chk("t6_irq", 32'(irq2), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
